// File: rtl/fp_mul_pipe.sv
// Four-stage IEEE-754 multiplier with a parametrised format and valid/ready on both sides.
// Uses round-to-nearest-even, treats zero exponents as zero (DAZ), flushes underflow to zero, and raises nv/of/uf/nx.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_z,
  output logic [3:0]   out_flags
);

  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * (MAN_W + 1);
  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_TOP = EW'((1 << EXP_W) - 1);

  // The special-case class is resolved in S1 and carried down to S4, where it overrides the result.
  typedef enum logic [1:0] {
    K_NORM,
    K_ZERO,
    K_INF,
    K_QNAN
  } kind_e;

  // ---------------------------------------------------------------- control
  logic en;
  logic v1, v2, v3;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------------------------------------------------------- S1 comb
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, b_nan, a_snan, b_snan;
  logic             a_inf, b_inf, a_zero, b_zero;
  kind_e            kind_d;
  logic             nv_d;
  logic signed [EW-1:0] exp_sum;

  assign {sa, ea, fa} = in_a;
  assign {sb, eb, fb} = in_b;

  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_snan = a_nan && !fa[MAN_W-1];
  assign b_snan = b_nan && !fb[MAN_W-1];
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;

  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    kind_d = K_NORM;
    nv_d   = 1'b0;
    if (a_nan || b_nan) begin
      kind_d = K_QNAN;
      nv_d   = a_snan || b_snan;
    end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
      kind_d = K_QNAN;
      nv_d   = 1'b1;
    end else if (a_inf || b_inf) begin
      kind_d = K_INF;
    end else if (a_zero || b_zero) begin
      kind_d = K_ZERO;
    end
  end

  // ---------------------------------------------------------------- stage registers
  logic                 s1_sign, s2_sign, s3_sign;
  kind_e                s1_kind, s2_kind, s3_kind;
  logic                 s1_nv, s2_nv, s3_nv;
  logic signed [EW-1:0] s1_exp, s2_exp, s3_exp;
  logic [MAN_W-1:0]     s1_fa, s1_fb;
  logic [PW-1:0]        s2_prod;
  logic [MAN_W-1:0]     s3_frac;
  logic                 s3_nx;

  // ---------------------------------------------------------------- S3 comb: normalise and round
  logic                 p_msb;
  logic [PW-2:0]        norm;
  logic [MAN_W-1:0]     frac_t, frac_r;
  logic                 guard, sticky, round_up, carry;
  logic signed [EW-1:0] exp_n;

  always_comb begin
    p_msb    = s2_prod[PW-1];
    // Drop the hidden bit; the product is either in [1,2) or [2,4).
    norm     = p_msb ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
    frac_t   = norm[PW-2 -: MAN_W];
    guard    = norm[MAN_W];
    sticky   = |norm[MAN_W-1:0];
    round_up = guard && (sticky || frac_t[0]);
    {carry, frac_r} = {1'b0, frac_t} + {{MAN_W{1'b0}}, round_up};
    exp_n    = s2_exp + $signed({{(EW-1){1'b0}}, p_msb}) + $signed({{(EW-1){1'b0}}, carry});
  end

  // ---------------------------------------------------------------- S4 comb: range check and pack
  logic [W-1:0] z_d;
  logic [3:0]   flags_d;

  always_comb begin
    z_d     = {s3_sign, {(W-1){1'b0}}};
    flags_d = 4'b0000;
    case (s3_kind)
      K_QNAN: begin
        z_d     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flags_d = {s3_nv, 3'b000};
      end
      K_INF:  z_d = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      K_ZERO: z_d = {s3_sign, {(W-1){1'b0}}};
      default: begin
        if (s3_exp >= EXP_TOP) begin
          z_d     = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d = 4'b0101;
        end else if (s3_exp[EW-1] || s3_exp == '0) begin
          z_d     = {s3_sign, {(W-1){1'b0}}};
          flags_d = 4'b0011;
        end else begin
          z_d     = {s3_sign, s3_exp[EXP_W-1:0], s3_frac};
          flags_d = {3'b000, s3_nx};
        end
      end
    endcase
  end

  // ---------------------------------------------------------------- sequential
  // NOTE: sequential state uses non-blocking assignments, so every stage samples the pre-edge values of the stage before it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      out_z     <= '0;
      out_flags <= '0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      if (v3) begin
        out_z     <= z_d;
        out_flags <= flags_d;
      end
    end
  end

  // NOTE: datapath registers are not reset; the stage-valid bits alone decide whether their contents are ever used.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_sign <= sa ^ sb;
      s1_kind <= kind_d;
      s1_nv   <= nv_d;
      s1_exp  <= exp_sum;
      s1_fa   <= fa;
      s1_fb   <= fb;

      s2_sign <= s1_sign;
      s2_kind <= s1_kind;
      s2_nv   <= s1_nv;
      s2_exp  <= s1_exp;
      s2_prod <= {1'b1, s1_fa} * {1'b1, s1_fb};

      s3_sign <= s2_sign;
      s3_kind <= s2_kind;
      s3_nv   <= s2_nv;
      s3_exp  <= exp_n;
      s3_frac <= frac_r;
      s3_nx   <= guard || sticky;
    end
  end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
Parametrised, pipelined IEEE-754 floating-point multiplier. It is the successor to the fixed 32-bit `mul` block.
- Format is configurable through exponent and mantissa widths.
- Adds valid/ready flow control on both sides, round-to-nearest-even, and exception flags.
- Sits between the operand stimulus/datapath source and the result sink. Fixed latency of 4 accepted-cycles.

Parameters:
EXP_W, 8, exponent field width (min 4)
MAN_W, 23, stored mantissa (fraction) width (min 4)
W, 1+EXP_W+MAN_W, total word width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
in_a  in  W  operand A, IEEE packed {sign, exp, frac}
in_b  in  W  operand B, same format
out_valid  out  1  result valid
out_ready  in  1  sink accepts result
out_z  out  W  product, same format
out_flags  out  4  {nv invalid, of overflow, uf underflow, nx inexact}

Behaviour:
Reset:
- Asynchronous; rst=1 immediately clears out_valid, out_z, out_flags and all stage-valid bits.
- In-flight operations are discarded, never emitted.
- First operand is accepted on the first edge after rst deasserts with in_valid=1.

Flow control:
- Global enable en = !out_valid || out_ready; in_ready = en.
- Transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- When en=0, every stage holds its data; out_z and out_flags stay stable while out_valid && !out_ready.
- Bubbles advance with the pipeline (not collapsed).
- Simultaneous output transfer and input acceptance in the same cycle is legal, with no loss or duplication.
- Results leave in acceptance order.

Pipeline (advances when en=1):
- S1: unpack, classify each operand (zero, normal, inf, qNaN, sNaN), sign = a.s ^ b.s.
  - Raw exp=0 is treated as zero (DAZ).
  - Unbiased sum e = ea + eb - BIAS, BIAS = 2^(EXP_W-1)-1, held in EXP_W+2 signed bits.
- S2: significand product of {1,frac_a} × {1,frac_b}, 2*(MAN_W+1) bits.
- S3: normalise and round.
  - If the product MSB is set, shift right 1 and e += 1.
  - Extract lsb, guard, sticky; round to nearest even (up if g && (s || lsb)).
  - On rounding carry-out, renormalise and e += 1.
  - nx = g || s.
- S4: range check, special-case override, pack. Loads out_z, out_flags and out_valid.
- Latency: result presented exactly 4 enabled edges after acceptance (4 cycles with no backpressure).

Special cases (priority order):
- Either operand NaN, or zero × inf: canonical qNaN = sign 0, exp all-ones, frac MSB 1, rest 0.
  - nv=1 for zero × inf or any sNaN input (exp all-ones, frac≠0, frac MSB 0).
  - Other flags 0.
- Inf × (non-zero or inf): signed infinity, flags 0.
- Zero × finite: signed zero, flags 0.
- Finite result with e ≥ 2^EXP_W - 1: signed infinity, of=1, nx=1.
- Finite result with e ≤ 0: flush to signed zero, uf=1, nx=1 (FTZ, no subnormals produced).
- Otherwise: normal packed result, nx from rounding.

Test Plan:
- Basic latency (defaults): in_a=0x40400000 (3.0), in_b=0x40000000 (2.0), out_ready=1 -> out_z=0x40C00000, flags=0000, out_valid exactly 4 cycles after acceptance.
- Rounding tie and above-half:
  - 0x3F800001 × 0x3FC00000 -> 0x3FC00002, nx=1 (tie, odd lsb, rounds up).
  - 0x3F800001 × 0x3F800001 -> 0x3F800002, nx=1.
- Specials:
  - 0x00000000 × 0x7F800000 -> 0x7FC00000, nv=1.
  - 0xFF800000 × 0x40000000 -> 0xFF800000, flags 0.
  - 0x7F800001 × 0x3F800000 -> 0x7FC00000, nv=1.
- Range:
  - 0x7F000000 × 0x7F000000 -> 0x7F800000, of=1, nx=1.
  - 0x00800000 × 0x3F000000 -> 0x00000000, uf=1, nx=1.
- Backpressure: stream 8 back-to-back pairs (k.0 × 2.0, k=1..8), drop out_ready for 3 cycles mid-stream -> in_ready=0 while stalled, out_z held stable, all 8 results 2k.0 delivered in order. rst pulsed mid-stream -> out_valid=0 immediately, no stale result afterwards.
- Double precision (EXP_W=11, MAN_W=52): 0x4008000000000000 × 0x4000000000000000 -> 0x4018000000000000, flags 0, latency 4.
